// File: rtl/io_pkg.sv
// Shared constants for the io_buffer pad bank.
// Latency: none (declarations only).
// Backpressure: none.
// Contents:
//   DIR_OUT / DIR_IN  per-bit direction encoding used on the dir port
package io_pkg;

  // A dir bit at DIR_OUT makes the core drive the pad.
  // A dir bit at DIR_IN releases the pad to high-Z so it can be read.
  localparam logic DIR_OUT = 1'b1;
  localparam logic DIR_IN  = 1'b0;

  // True when a direction bit selects the core as pad driver.
  function automatic logic is_drive(input logic dir_bit);
    return dir_bit == DIR_OUT;
  endfunction

endpackage

// File: rtl/io_sync_chain.sv
// Per-bit synchronizer and edge detector for asynchronous pad inputs.
// Latency: pad -> sync is SYNC_STAGES clocks; rise/fall assert in the same cycle sync changes.
// Backpressure: none; samples every clock.
// Ports:
//   clock, reset_n    system clock, synchronous active-low reset
//   pad   [WIDTH]     raw pad value (asynchronous to clock)
//   sync  [WIDTH]     pad value after SYNC_STAGES flops
//   rise  [WIDTH]     1-cycle pulse on a 0->1 transition of sync
//   fall  [WIDTH]     1-cycle pulse on a 1->0 transition of sync
module io_sync_chain #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pad,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // chain[0] is the first (metastability-exposed) stage.
  // chain[SYNC_STAGES-1] is the stable output stage.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
  // prev holds the previous value of sync.
  logic [WIDTH-1:0]                  prev;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pad};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];

  // Both terms come straight from flops, so each pulse is glitch-free.
  // Each pulse lasts exactly one cycle: prev catches up on the next edge.
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/io_buffer.sv
// Bidirectional tristate pad bank with a synchronized, edge-detected view of the pads.
// Latency: io <-> in_data is combinational; in_sync/in_rise/in_fall lag the pad by SYNC_STAGES clocks.
// Backpressure: none; the tristate path ignores clock and reset.
// Ports:
//   clock, reset_n  system clock, synchronous active-low reset (affects sync path only)
//   io       [W]    external pad (inout)
//   dir      [W]    1 = drive io from out_data, 0 = release to high-Z
//   out_data [W]    value driven onto io where dir=1
//   in_data  [W]    raw pad value, combinational
//   in_sync  [W]    synchronized pad value
//   in_rise  [W]    1-cycle pulse on a rising edge of in_sync
//   in_fall  [W]    1-cycle pulse on a falling edge of in_sync
module io_buffer
  import io_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  inout  wire  [WIDTH-1:0] io,
  input  logic [WIDTH-1:0] dir,
  input  logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] in_rise,
  output logic [WIDTH-1:0] in_fall
);

  // The pad path is deliberately free of clock and reset.
  // Pads stay under dir control even while reset is held.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign io[i]      = is_drive(dir[i]) ? out_data[i] : 1'bz;
    assign in_data[i] = io[i];
  end

  io_sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .pad     (io),
    .sync    (in_sync),
    .rise    (in_rise),
    .fall    (in_fall)
  );

endmodule

// File: tb/tb_io_buffer.sv
// Self-checking bench for io_buffer: directed pad/edge/reset scenarios followed by random traffic.
// The reference model records the pad level at every clock edge and derives the expected
// synchronized/edge outputs from edge counts since the last reset.
module tb_io_buffer;

  localparam int W = 4;
  localparam int S = 2;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [W-1:0] dir;
  logic [W-1:0] out_data;
  logic [W-1:0] tb_en;
  logic [W-1:0] tb_val;
  wire  [W-1:0] io;
  logic [W-1:0] in_data;
  logic [W-1:0] in_sync;
  logic [W-1:0] in_rise;
  logic [W-1:0] in_fall;

  int checks   = 0;
  int failures = 0;

  // Model state: pad level captured at each clock edge, and the index of the last reset edge.
  logic [W-1:0] samp [0:4095];
  int           n          = 0;
  int           last_reset = -1;

  always #5 clock = ~clock;

  // Bench-side external driver plus the pad-ring pull-up.
  for (genvar i = 0; i < W; i++) begin : g_tb_pad
    assign io[i] = tb_en[i] ? tb_val[i] : 1'bz;
    pullup pu (io[i]);
  end

  io_buffer #(
    .WIDTH       (W),
    .SYNC_STAGES (S)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .io       (io),
    .dir      (dir),
    .out_data (out_data),
    .in_data  (in_data),
    .in_sync  (in_sync),
    .in_rise  (in_rise),
    .in_fall  (in_fall)
  );

  // Expected pad level.
  // A driven bit carries out_data.
  // A released bit carries the bench driver if enabled, otherwise the pull-up (1).
  function automatic logic [W-1:0] pad_level();
    return (dir & out_data) | (~dir & tb_en & tb_val) | (~dir & ~tb_en);
  endfunction

  // Pad value sampled k edges before the most recent edge.
  // Returns 0 if a reset edge lies between that sample and now.
  function automatic logic [W-1:0] delayed(input int k);
    int e;
    e = n - 1 - k;
    if (e > last_reset) return samp[e];
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called just after a negedge once inputs are set.
  // Checks the combinational path, takes one clock edge, then checks the synchronized outputs.
  task automatic step();
    logic [W-1:0] s_now;
    logic [W-1:0] s_old;
    #1;
    chk("in_data", in_data, pad_level());
    chk("io", io, pad_level());
    @(posedge clock);
    samp[n] = pad_level();
    if (!reset_n) last_reset = n;
    n++;
    @(negedge clock);
    s_now = delayed(S - 1);
    s_old = delayed(S);
    chk("in_sync", in_sync, s_now);
    chk("in_rise", in_rise, s_now & ~s_old);
    chk("in_fall", in_fall, ~s_now & s_old);
  endtask

  initial begin
    reset_n  = 1'b0;
    dir      = '0;
    out_data = '0;
    tb_en    = '1;
    tb_val   = '0;
    @(negedge clock);
    repeat (2) step();
    chk("rst_sync", in_sync, '0);
    chk("rst_rise", in_rise, '0);
    chk("rst_fall", in_fall, '0);
    reset_n = 1'b1;

    // Drive mode: the pad loops back out_data.
    dir = '1; tb_en = '0; out_data = '1;
    step();
    chk("drv1_io", io, '1);
    chk("drv1_in", in_data, '1);
    out_data = '0;
    step();
    chk("drv0_io", io, '0);
    chk("drv0_in", in_data, '0);

    // Input mode: the core holds out_data at the opposite level, so any leak would corrupt the pad.
    dir = '0; tb_en = '1; tb_val = '1; out_data = '0;
    step();
    chk("in1", in_data, '1);
    tb_val = '0; out_data = '1;
    step();
    chk("in0", in_data, '0);

    // Released and undriven: only the pull-up remains.
    tb_en = '0;
    step();
    chk("float_io", io, '1);
    chk("float_in", in_data, io);

    // Rising edge: in_sync follows two clocks later, with a single-cycle in_rise.
    tb_en = '1; tb_val = '0;
    repeat (3) step();
    tb_val = '1;
    step();
    chk("rise_lat1", in_sync, '0);
    step();
    chk("rise_lat2", in_sync, '1);
    chk("rise_pulse", in_rise, '1);
    step();
    chk("rise_end", in_rise, '0);

    // Falling edge.
    tb_val = '0;
    step();
    step();
    chk("fall_pulse", in_fall, '1);
    step();
    chk("fall_end", in_fall, '0);

    // Reset mid-operation with the pad held high.
    tb_val = '1;
    repeat (3) step();
    chk("pre_rst_sync", in_sync, '1);
    reset_n = 1'b0;
    step();
    chk("mid_rst_sync", in_sync, '0);
    chk("mid_rst_rise", in_rise, '0);
    chk("mid_rst_fall", in_fall, '0);

    // Pads stay under dir control during reset.
    dir = '1; tb_en = '0; out_data = 4'b1010;
    step();
    chk("rst_drive_io", io, 4'b1010);

    // Release with the pad back at 1.
    dir = '0; tb_en = '1; tb_val = '1;
    reset_n = 1'b1;
    step();
    chk("post_rst_rise1", in_rise, '0);
    step();
    chk("post_rst_rise2", in_rise, '1);
    step();
    chk("post_rst_rise3", in_rise, '0);

    // Random traffic.
    // The bench only drives bits the core has released, and reset is asserted occasionally.
    repeat (400) begin
      dir      = W'($urandom);
      out_data = W'($urandom);
      tb_en    = W'($urandom) & ~dir;
      tb_val   = W'($urandom);
      reset_n  = ($urandom_range(0, 19) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
